booth_mul_r4_seq: RTL
=====================

// Module: booth_mul_r4_seq
// PURPOSE
//  Sequential radix-4 (modified Booth) N x N multiplier: two multiplier bits per cycle.
//  Per-operation signed/unsigned mode; valid/ready handshake on both sides.
//  Successor to the 1-bit-per-cycle Booth unit. Roughly halves latency and adds
//  output backpressure. Sits between the user I/O pin logic and the result-reduction path.
// PARAMETERS
//  N   16  operand width; must be even and >= 4 (elaboration error otherwise)
// PORTS
//  Clk         in   1    clock, all state on rising edge
//  Rst         in   1    synchronous, active-high reset
//  In_Valid    in   1    operands + mode presented
//  In_Ready    out  1    block can accept an operation this cycle
//  Signed_Mode in   1    1: M,R two's complement; 0: M,R unsigned (sampled with operands)
//  M           in   N    multiplicand
//  R           in   N    multiplier
//  Out_Valid   out  1    P holds a completed product
//  Out_Ready   in   1    consumer takes P this cycle
//  P           out  2N   product (signed or unsigned per captured mode)
// BEHAVIOUR
//  Reset: state IDLE, Out_Valid=0, P=0, In_Ready=1, internal regs 0.
//  Internal width W=N+2; M,R sign-extended (Signed_Mode=1) or zero-extended (0) to W.
//  Step count K=W/2=N/2+1 (N=16 -> K=9).
//  States:
//   IDLE - In_Ready=1; accept on In_Valid -> RUN, cnt=K, latch A=ext(M), Prod={0,ext(R)}, guard=0.
//   RUN  - one radix-4 step per cycle; cnt-- each cycle; In_Ready=0; In_Valid ignored.
//          Leaves RUN when the cnt==1 step completes.
//   DONE - Out_Valid=1, P stable. On Out_Ready: accept a new op if In_Valid -> RUN, else -> IDLE.
//  In_Ready = (state==IDLE) | (state==DONE & Out_Ready).
//  Latency: accept edge e0 -> Out_Valid=1 after edge e0+K (9 cycles at N=16).
//  Throughput: one op per K+1 cycles when the consumer never stalls.
//  Step i: digit d = {Prod[1],Prod[0],guard} -> 000/111:0, 001/010:+A, 011:+2A, 100:-2A, 101/110:-A.
//   Negation = ~operand with carry-in 1.
//   Adder width W+1, so +-2A cannot overflow.
//   Prod is shifted right arithmetically by 2; guard <= old Prod[1].
//  P = low 2N bits of the final W+W product. The result is exact in both modes:
//   unsigned fits 2N unsigned; signed fits 2N two's complement, including (-2^(N-1))^2.
//  Backpressure: while Out_Valid & !Out_Ready, P and Out_Valid hold; no new op is accepted.
//  Simultaneous Out_Ready & In_Valid in DONE: result retires and new op is accepted in the same edge.
//   Out_Valid drops next cycle.
//  Rst mid-RUN or mid-DONE: operation discarded, reset values next cycle. No partial P is ever visible.
//  P changes only on the edge entering DONE; it holds its last value in IDLE/RUN (reset: 0).
//  Mode and operands are captured at accept; input changes afterwards have no effect.
// STRUCTURE
//  Package booth_pkg:
//   - state enum IDLE/RUN/DONE (2-bit)
//   - Booth digit encodings (ZERO, P1, P2, N1, N2)
//   - function booth_steps(N) returning K
//  Sub-module booth_r4_pp_sel (combinational):
//   - inputs 3-bit digit and A (W bits)
//   - outputs B (W+1 bits) and Ci
//   - recode plus operand mux, reusable by a future pipelined variant
//  Top holds FSM, counter ($clog2(K+1) bits), A/Prod/guard regs, adder, P/Out_Valid regs.
// TESTING  (N=16 unless noted)
//  1 unsigned M=0xFFFF,R=0xFFFF -> P=0xFFFE0001; Out_Valid exactly 9 cycles after accept.
//  2 signed M=0x8000,R=0x8000 -> P=0x40000000; signed M=0xFFFD(-3),R=0x0005 -> P=0xFFFFFFF1;
//    unsigned same operands -> P=0x0004FFF1.
//  3 Out_Ready=0 for 5 cycles in DONE -> P, Out_Valid stable, In_Ready=0;
//    then Out_Ready=1 & In_Valid=1 same cycle -> new op accepted, its result 9 cycles later.
//  4 Rst asserted at 4th RUN cycle -> next cycle Out_Valid=0, P=0, In_Ready=1;
//    next op 7*6 -> P=42 correct.
//  5 In_Valid with different M,R held throughout RUN -> ignored; P equals first op's product.
//  6 10k random ops, random mode and random Out_Ready, N=8 and N=16 -> P matches behavioural
//    model; no result lost or duplicated.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
// The sequential unit uses them today; a pipelined variant can reuse the digit recoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_N1   = 3'd3,
        BD_N2   = 3'd4
    } booth_digit_e;

    // Operands are extended by two bits, and each step retires two of them.
    function automatic int booth_steps(input int n);
        return (n + 2) / 2;
    endfunction

    // Window is {b[i+1], b[i], b[i-1]} of the extended multiplier.
    function automatic booth_digit_e booth_recode(input logic [2:0] bits);
        booth_digit_e d;
        case (bits)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_N2;
            3'b101, 3'b110: d = BD_N1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Radix-4 Booth partial-product selector: recodes a 3-bit window and returns
// the W+1-bit addend plus carry-in. Subtraction is expressed as ~operand with carry-in 1.
module booth_r4_pp_sel #(
    parameter int W = 18
) (
    input  logic [2:0] digit,
    input  logic [W-1:0] a,
    output logic [W:0]   b,
    output logic         ci
);
    import booth_pkg::*;

    booth_digit_e sel;
    logic [W:0]   a_x1;
    logic [W:0]   a_x2;

    assign sel  = booth_recode(digit);
    assign a_x1 = {a[W-1], a};
    // A is an extended N-bit value, so doubling it still fits in W+1 bits.
    assign a_x2 = {a, 1'b0};

    always_comb begin
        b  = '0;
        ci = 1'b0;
        case (sel)
            BD_P1: b = a_x1;
            BD_P2: b = a_x2;
            BD_N1: begin
                b  = ~a_x1;
                ci = 1'b1;
            end
            BD_N2: begin
                b  = ~a_x2;
                ci = 1'b1;
            end
            default: b = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4_seq.sv
// Sequential radix-4 Booth N x N multiplier, two multiplier bits per cycle,
// per-operation signed/unsigned mode, valid/ready on both the operand and result sides.
module booth_mul_r4_seq #(
    parameter int N = 16
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           In_Valid,
    output logic           In_Ready,
    input  logic           Signed_Mode,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   R,
    output logic           Out_Valid,
    input  logic           Out_Ready,
    output logic [2*N-1:0] P
);
    import booth_pkg::*;

    localparam int W  = N + 2;
    localparam int K  = booth_steps(N);
    localparam int CW = $clog2(K + 1);

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_n
            $error("booth_mul_r4_seq: N must be even and >= 4");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Operands transfer when In_Valid & In_Ready; the product retires when
    // Out_Valid & Out_Ready. Ready never depends on the same side's valid, and
    // once Out_Valid is raised it and P hold until the product retires.

    state_e           state;
    state_e           state_nxt;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     a_reg;
    logic [2*W-1:0]   prod;
    logic             guard;

    logic             accept;
    logic             step;
    logic             last_step;
    logic [W-1:0]     m_ext;
    logic [W-1:0]     r_ext;
    logic [W:0]       pp_b;
    logic             pp_ci;
    logic [W:0]       sum;
    logic [2*W-1:0]   prod_nxt;

    assign m_ext = Signed_Mode ? {{2{M[N-1]}}, M} : {2'b00, M};
    assign r_ext = Signed_Mode ? {{2{R[N-1]}}, R} : {2'b00, R};

    booth_r4_pp_sel #(
        .W (W)
    ) u_pp_sel (
        .digit ({prod[1:0], guard}),
        .a     (a_reg),
        .b     (pp_b),
        .ci    (pp_ci)
    );

    // Accumulate on the upper half with one bit of headroom, then shift the
    // whole product right by two, arithmetically.
    assign sum       = {prod[2*W-1], prod[2*W-1:W]} + pp_b + {{W{1'b0}}, pp_ci};
    assign prod_nxt  = {sum[W], sum, prod[W-1:2]};
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (In_Valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (Out_Ready) begin
                    state_nxt = In_Valid ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: In_Ready = 1'b1;
            RUN:  step     = 1'b1;
            DONE: begin
                Out_Valid = 1'b1;
                In_Ready  = Out_Ready;
            end
            default: In_Ready = 1'b0;
        endcase
        accept = In_Valid & In_Ready;
    end

    // P is written only on the final step, so a partial product is never exposed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt   <= '0;
            a_reg <= '0;
            prod  <= '0;
            guard <= 1'b0;
            P     <= '0;
        end else if (accept) begin
            cnt   <= CW'(K);
            a_reg <= m_ext;
            prod  <= {{W{1'b0}}, r_ext};
            guard <= 1'b0;
        end else if (step) begin
            cnt   <= cnt - CW'(1);
            prod  <= prod_nxt;
            guard <= prod[1];
            if (last_step) begin
                P <= prod_nxt[2*N-1:0];
            end
        end
    end

endmodule
